pc_unit: RTL and testbench

- Holds the program counter downstream of the PC-source multiplexer and loads the selected next-PC under control-unit write enables.
- Also owns the exception sequence:
  - captures EPC;
  - fetches the handler address byte from the fixed vector table in memory;
  - loads that byte into PC.
- The PC and EPC outputs feed the memory address path and the EPC input of the PC-source multiplexer.

---
 rtl/pc_unit.sv | 153 +++++++++++++++
 tb/tb_pc_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit
//   Program counter register with the exception entry sequence. In normal
//   operation the PC loads the next-PC value selected upstream under the
//   control-unit write enables. On an exception request the unit saves
//   EPC = PC - 4, fetches the handler address byte from the vector table in
//   memory and loads that byte into PC.
//
// Handshake: ExcMemRead is a request level held from REQ through WAIT with
//   ExcAddr stable. The memory is not back-pressured; it must present valid
//   MemData MEM_LAT cycles after ExcMemRead rises, and the byte is sampled on
//   the edge that leaves LOAD.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   PCIn         next-PC value from the PC-source multiplexer
//   PCWrite      unconditional PC load enable
//   PCWriteCond  conditional (branch) PC load enable, qualified by Zero
//   Zero         ALU zero flag
//   ExcReq       exception request pulse
//   ExcCause     exception cause code (00 opcode, 01 overflow, 10 div0, 11 rsvd)
//   MemData      memory read data, bits [7:0] used
//   PC           current program counter
//   EPC          exception program counter
//   ExcMemRead   vector fetch read request
//   ExcAddr      vector byte address, zero when no fetch is requested
//   ExcBusy      exception sequence in progress (REQ/WAIT/LOAD)
//   ExcDone      one-cycle pulse after the handler address is loaded
module pc_unit #(
   parameter int WIDTH    = 32,
   parameter int VEC_BASE = 253,
   parameter int MEM_LAT  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] PCIn,
   input  logic             PCWrite,
   input  logic             PCWriteCond,
   input  logic             Zero,
   input  logic             ExcReq,
   input  logic [1:0]       ExcCause,
   input  logic [WIDTH-1:0] MemData,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] EPC,
   output logic             ExcMemRead,
   output logic [WIDTH-1:0] ExcAddr,
   output logic             ExcBusy,
   output logic             ExcDone
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_LOAD = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0]       LAT_INIT   = 3'(MEM_LAT);
   localparam logic [WIDTH-1:0] VEC_BASE_W = WIDTH'(VEC_BASE);
   localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [1:0]       cause_q, cause_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] vec_off;
   logic             pc_load_req;

   // Only the low byte of the read data carries the handler address.
   logic mem_data_unused;
   assign mem_data_unused = ^MemData[WIDTH-1:8];

   assign pc_load_req = PCWrite | (PCWriteCond & Zero);

   // Reserved cause 11 falls back to the opcode-invalid vector.
   always_comb begin
      vec_off = '0;
      case (cause_q)
         2'b01:   vec_off = WIDTH'(1);
         2'b10:   vec_off = WIDTH'(2);
         default: vec_off = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            // Exception entry wins over any PC load in the same cycle.
            if (ExcReq) begin
               epc_d   = pc_q - FOUR;
               cause_d = ExcCause;
               state_d = S_REQ;
            end else if (pc_load_req) begin
               pc_d = PCIn;
            end
         end
         S_REQ: begin
            cnt_d   = LAT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // WAIT lasts MEM_LAT cycles, so REQ+WAIT spans MEM_LAT+1.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            pc_d    = {{(WIDTH-8){1'b0}}, MemData[7:0]};
            state_d = S_DONE;
         end
         S_DONE: begin
            // Normal PC loads resume here; a new ExcReq is taken next cycle.
            if (pc_load_req) begin
               pc_d = PCIn;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         epc_q   <= '0;
         cause_q <= 2'b00;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   assign PC         = pc_q;
   assign EPC        = epc_q;
   assign ExcMemRead = (state_q == S_REQ) || (state_q == S_WAIT);
   assign ExcAddr    = ExcMemRead ? (VEC_BASE_W + vec_off) : '0;
   assign ExcBusy    = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_LOAD);
   assign ExcDone    = (state_q == S_DONE);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit. Two instances share the data/control inputs:
// u_dut1 (MEM_LAT=1) carries the directed sequence, u_dut3 (MEM_LAT=3) is
// held in reset until the final latency check.
module tb_pc_unit;

   localparam int W = 32;

   logic         clk;
   logic         rst_n1, rst_n3;
   logic [W-1:0] pc_in, mem_data;
   logic         pc_write, pc_write_cond, zero, exc_req;
   logic [1:0]   exc_cause;

   logic [W-1:0] pc1, epc1, addr1, pc3, epc3, addr3;
   logic         rd1, busy1, done1, rd3, busy3, done3;

   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_err = 0;

   pc_unit #(.WIDTH(W), .VEC_BASE(253), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .reset(rst_n1), .PCIn(pc_in), .PCWrite(pc_write),
      .PCWriteCond(pc_write_cond), .Zero(zero), .ExcReq(exc_req),
      .ExcCause(exc_cause), .MemData(mem_data), .PC(pc1), .EPC(epc1),
      .ExcMemRead(rd1), .ExcAddr(addr1), .ExcBusy(busy1), .ExcDone(done1)
   );

   pc_unit #(.WIDTH(W), .VEC_BASE(253), .MEM_LAT(3)) u_dut3 (
      .clk(clk), .reset(rst_n3), .PCIn(pc_in), .PCWrite(pc_write),
      .PCWriteCond(pc_write_cond), .Zero(zero), .ExcReq(exc_req),
      .ExcCause(exc_cause), .MemData(mem_data), .PC(pc3), .EPC(epc3),
      .ExcMemRead(rd3), .ExcAddr(addr3), .ExcBusy(busy3), .ExcDone(done3)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic drive_idle();
      pc_in         = '0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      zero          = 1'b0;
      exc_req       = 1'b0;
      exc_cause     = 2'b00;
   endtask

   // scoreboard: pop the oldest expectation and compare
   task automatic check(input string tag, input logic [W-1:0] obs);
      logic [W-1:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s: observed %h, expected queue empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   initial begin
      int rd_cnt;
      int load_edge;

      drive_idle();
      mem_data = '0;
      rst_n1   = 1'b0;
      rst_n3   = 1'b0;
      tick();
      tick();

      // reset state
      push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
      check("rst_pc", pc1);
      check("rst_epc", epc1);
      check("rst_rd", 32'(rd1));
      check("rst_addr", addr1);
      check("rst_busy", 32'(busy1));
      check("rst_done", 32'(done1));
      rst_n1 = 1'b1;

      // unconditional load, then hold
      pc_write = 1'b1; pc_in = 32'h4; push(32'h4);
      tick(); check("pcwrite", pc1);
      pc_write = 1'b0; pc_in = 32'h100; push(32'h4);
      tick(); check("pc_hold", pc1);

      // conditional load
      pc_write_cond = 1'b1; pc_in = 32'h40; zero = 1'b0; push(32'h4);
      tick(); check("cond_z0", pc1);
      zero = 1'b1; push(32'h40);
      tick(); check("cond_z1", pc1);
      pc_write_cond = 1'b0; zero = 1'b0; pc_write = 1'b1; pc_in = 32'h80; push(32'h80);
      tick(); check("pcwrite_prio", pc1);
      pc_in = 32'h10; push(32'h10);
      tick(); check("pc_set10", pc1);

      // exception cause 01 with competing PCWrite
      exc_req = 1'b1; exc_cause = 2'b01; pc_write = 1'b1; pc_in = 32'h200;
      mem_data = 32'hAABBCC5A;
      push(32'hC); push(32'h10); push(32'h1); push(32'hFE); push(32'h1); push(32'h0);
      tick();
      drive_idle();
      check("exc1_epc", epc1);
      check("exc1_pc", pc1);
      check("exc1_req_rd", 32'(rd1));
      check("exc1_req_addr", addr1);
      check("exc1_req_busy", 32'(busy1));
      check("exc1_req_done", 32'(done1));
      push(32'h1); push(32'hFE); push(32'h10);
      tick();
      check("exc1_wait_rd", 32'(rd1));
      check("exc1_wait_addr", addr1);
      check("exc1_wait_pc", pc1);
      push(32'h0); push(32'h1); push(32'h0); push(32'h10);
      tick();
      check("exc1_load_rd", 32'(rd1));
      check("exc1_load_busy", 32'(busy1));
      check("exc1_load_done", 32'(done1));
      check("exc1_load_pc", pc1);
      push(32'h5A); push(32'h1); push(32'h0);
      tick();
      check("exc1_done_pc", pc1);
      check("exc1_done_pulse", 32'(done1));
      check("exc1_done_busy", 32'(busy1));
      push(32'h0); push(32'h5A);
      tick();
      check("exc1_done_once", 32'(done1));
      check("exc1_idle_pc", pc1);

      // reserved cause 11, requests while busy are ignored
      exc_req = 1'b1; exc_cause = 2'b11;
      push(32'h56); push(32'hFD);
      tick();
      check("exc3_epc", epc1);
      check("exc3_addr", addr1);
      exc_req = 1'b1; exc_cause = 2'b10; pc_write = 1'b1; pc_in = 32'h999;
      push(32'h5A); push(32'h56); push(32'hFD);
      tick();
      check("busy_ign_pc", pc1);
      check("busy_ign_epc", epc1);
      check("busy_ign_addr", addr1);
      drive_idle();
      mem_data = 32'h12345633;
      push(32'h5A); push(32'h56);
      tick();
      check("exc3_load_pc", pc1);
      check("exc3_load_epc", epc1);
      push(32'h33);
      tick();
      check("exc3_done_pc", pc1);
      tick();

      // cause 10, then PCWrite honoured in DONE while ExcReq is not
      exc_req = 1'b1; exc_cause = 2'b10;
      push(32'h2F); push(32'hFF);
      tick();
      check("exc2_epc", epc1);
      check("exc2_addr", addr1);
      drive_idle();
      mem_data = 32'h00000077;
      tick();
      tick();
      push(32'h77); push(32'h1);
      tick();
      check("exc2_done_pc", pc1);
      check("exc2_done_pulse", 32'(done1));
      pc_write = 1'b1; pc_in = 32'h0; exc_req = 1'b1; exc_cause = 2'b01;
      push(32'h0); push(32'h2F); push(32'h0); push(32'h0);
      tick();
      check("done_pcwrite_pc", pc1);
      check("done_excreq_epc", epc1);
      check("done_excreq_busy", 32'(busy1));
      check("done_excreq_rd", 32'(rd1));
      drive_idle();

      // PC=0 wraps EPC, then reset during WAIT aborts
      exc_req = 1'b1; exc_cause = 2'b00;
      push(32'hFFFFFFFC);
      tick();
      check("epc_wrap", epc1);
      drive_idle();
      mem_data = 32'hDEADBEEF;
      push(32'h1);
      tick();
      check("abort_in_wait", 32'(rd1));
      rst_n1 = 1'b0;
      push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
      tick();
      check("abort_pc", pc1);
      check("abort_epc", epc1);
      check("abort_rd", 32'(rd1));
      check("abort_addr", addr1);
      check("abort_busy", 32'(busy1));
      check("abort_done", 32'(done1));
      rst_n1 = 1'b1;
      push(32'h0); push(32'h0);
      tick();
      tick();
      check("abort_no_load_pc", pc1);
      check("abort_idle_busy", 32'(busy1));

      // MEM_LAT=3 instance: 4 read cycles, PC loaded at 5th edge after REQ entry
      rst_n3 = 1'b1;
      pc_write = 1'b1; pc_in = 32'h20;
      push(32'h20);
      tick();
      check("lat3_pc_init", pc3);
      drive_idle();
      exc_req = 1'b1; exc_cause = 2'b00;
      mem_data = 32'hFFFFFFA5;
      push(32'h1C); push(32'hFD);
      tick();
      drive_idle();
      check("lat3_epc", epc3);
      check("lat3_addr", addr3);
      rd_cnt    = rd3 ? 1 : 0;
      load_edge = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (rd3) rd_cnt++;
         if (pc3 == 32'hA5 && load_edge == 0) load_edge = k;
      end
      push(32'd4); push(32'd5); push(32'hA5);
      check("lat3_rd_cycles", 32'(rd_cnt));
      check("lat3_load_edge", 32'(load_edge));
      check("lat3_pc", pc3);

      if (exp_q.size() != 0) begin
         n_err++;
         $error("FAIL leftover_exp: observed %0d entries, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
